lb_stream_ctrl: RTL and testbench

//   Frame sequencer for the vertical-stencil linebuffer conv pipeline (KH-row linebuffer + MAC tree).

---
 rtl/lb_stream_ctrl_if.sv | 27 ++
 rtl/lb_stream_ctrl.sv | 102 ++++++++++
 tb/tb_lb_stream_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lb_stream_ctrl_if.sv
// Handshake and position bundle between the linebuffer frame sequencer and its
// pixel source, result sink and linebuffer.
interface lb_stream_ctrl_if #(
  parameter int unsigned CW = 4
);
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic          lb_wen;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          frame_done;

  modport slave (
    input  start, in_valid, out_ready,
    output busy, in_ready, lb_wen, out_valid, out_last, col, row, frame_done
  );

  modport master (
    output start, in_valid, out_ready,
    input  busy, in_ready, lb_wen, out_valid, out_last, col, row, frame_done
  );
endinterface

// File: rtl/lb_stream_ctrl.sv
// Frame sequencer for a KH-row vertical-stencil linebuffer: counts pixels and rows,
// gates linebuffer writes with the input handshake and masks results while priming.
module lb_stream_ctrl #(
  parameter int unsigned IMG_W = 10,
  parameter int unsigned IMG_H = 10,
  parameter int unsigned KH    = 3,
  parameter int unsigned CW    = 4
) (
  input logic              clk,
  input logic              rst_n,
  lb_stream_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST      = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ROW_FILL_LAST = (KH > 1) ? CW'(KH - 2) : '0;
  // A single-row stencil needs no priming, so a frame starts straight in STREAM.
  localparam state_t        START_STATE   = (KH > 1) ? FILL : STREAM;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [CW-1:0] w_col_nxt;
  logic [CW-1:0] w_row_nxt;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_row_end;
  logic          w_frame_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_in_ready  = (r_state == FILL) | ((r_state == STREAM) & bus.out_ready);
    w_accept    = bus.in_valid & w_in_ready;
    w_row_end   = (r_col == COL_LAST);
    w_frame_end = w_row_end & (r_row == ROW_LAST);
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;

    if (w_accept) begin
      if (w_row_end) begin
        w_col_nxt = '0;
        w_row_nxt = r_row + 1'b1;
      end else begin
        w_col_nxt = r_col + 1'b1;
      end
    end

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = START_STATE;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      FILL: begin
        if (w_accept && w_row_end && (r_row == ROW_FILL_LAST)) begin
          w_state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (w_accept && w_frame_end) begin
          w_state_nxt = DONE;
          w_row_nxt   = '0;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_col_nxt   = '0;
        w_row_nxt   = '0;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.lb_wen     = w_accept;
  assign bus.out_valid  = (r_state == STREAM) & bus.in_valid;
  assign bus.out_last   = (r_state == STREAM) & bus.in_valid & w_frame_end;
  assign bus.busy       = (r_state != IDLE);
  assign bus.frame_done = (r_state == DONE);
  assign bus.col        = r_col;
  assign bus.row        = r_row;

endmodule

// File: tb/tb_lb_stream_ctrl.sv
// Bench for lb_stream_ctrl: frame-level pixel-index reference model plus a queue
// linebuffer fed by lb_wen, evaluating a 3/5/7 vertical stencil.
module tb_lb_stream_ctrl;

  localparam int W     = 10;
  localparam int H     = 10;
  localparam int KH    = 3;
  localparam int CW    = 4;
  localparam int FILLN = (KH - 1) * W;
  localparam int TOT   = W * H;
  localparam int RES   = (H - KH + 1) * W;

  logic clk;
  logic rst_n;

  lb_stream_ctrl_if #(.CW(CW)) bus ();

  lb_stream_ctrl #(
    .IMG_W(W),
    .IMG_H(H),
    .KH   (KH),
    .CW   (CW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 active frame, 2 done; mn = pixels accepted so far.
  int mph = 0;
  int mn  = 0;
  bit mknown = 0;
  int base = 0;
  int pix  = 0;
  int nres = 0;
  int nwen = 0;
  int first_res = -1;
  int lbq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic iv, input logic ordy);
    logic e_inr, e_ov, e_last, e_wen, w;
    int   obs_r, exp_r;
    @(negedge clk);
    rst_n         = rst;
    bus.start     = st;
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    pix           = base + mn;
    #1;
    e_inr  = (mph == 1) && ((mn < FILLN) || ordy);
    e_ov   = (mph == 1) && (mn >= FILLN) && iv;
    e_last = e_ov && (mn == TOT - 1);
    e_wen  = iv && e_inr;
    if (mknown) begin
      chk("busy",       bus.busy,       mph != 0);
      chk("in_ready",   bus.in_ready,   e_inr);
      chk("lb_wen",     bus.lb_wen,     e_wen);
      chk("out_valid",  bus.out_valid,  e_ov);
      chk("out_last",   bus.out_last,   e_last);
      chk("frame_done", bus.frame_done, mph == 2);
      chk("col",        bus.col,        mn % W);
      chk("row",        bus.row,        mn / W);
      if (bus.out_valid === 1'b1 && ordy) begin
        if (lbq.size() < 2 * W) begin
          chk("lb_depth", lbq.size(), 2 * W);
        end else begin
          obs_r = 3 * lbq[lbq.size() - 2 * W] + 5 * lbq[lbq.size() - W] + 7 * pix;
          exp_r = 3 * (base + mn - 2 * W) + 5 * (base + mn - W) + 7 * (base + mn);
          chk("result", obs_r, exp_r);
          if (nres == 0) first_res = obs_r;
        end
        nres++;
      end
    end
    w = bus.lb_wen;
    if (w === 1'b1) begin
      lbq.push_back(pix);
      nwen++;
      if (lbq.size() > 2 * W) void'(lbq.pop_front());
    end
    @(posedge clk);
    if (!rst) begin
      mph    = 0;
      mn     = 0;
      mknown = 1;
    end else begin
      case (mph)
        0: if (st) begin mph = 1; mn = 0; end
        1: if (iv && e_inr) begin
             if (mn == TOT - 1) begin mph = 2; mn = 0; end
             else mn++;
           end
        default: mph = 0;
      endcase
    end
  endtask

  task automatic run_frame(input int b, input bit rnd_v, input bit rnd_r,
                           input int stall_n, input int pulse_n);
    logic st, iv, ordy;
    bit   stalled;
    stalled   = 0;
    base      = b;
    nres      = 0;
    nwen      = 0;
    first_res = -1;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 2000 && mph != 0; k++) begin
      if (mph == 1 && mn == stall_n && !stalled) begin
        for (int s = 0; s < 5; s++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        stalled = 1;
      end
      st   = (pulse_n >= 0) && (((mph == 1) && (mn == pulse_n)) || (mph == 2));
      iv   = rnd_v ? logic'($urandom_range(0, 1)) : 1'b1;
      ordy = rnd_r ? logic'($urandom_range(0, 1)) : 1'b1;
      cyc(1'b1, st, iv, ordy);
    end
    chk("frame_end",    mph,       0);
    chk("results",      nres,      RES);
    chk("writes",       nwen,      TOT);
    chk("first_result", first_res, 3 * b + 5 * (b + W) + 7 * (b + 2 * W));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset held two cycles with start and in_valid asserted.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);

    // Full ramp frame, no stalls.
    run_frame(0, 0, 0, -1, -1);
    chk("first_190", first_res, 190);

    // Sink backpressure at row 4, col 3.
    run_frame(0, 0, 0, 4 * W + 3, -1);
    chk("stall_first_190", first_res, 190);

    // Random source bubbles, then random bubbles on both sides.
    run_frame(0, 1, 0, -1, -1);
    run_frame(500, 1, 1, -1, -1);

    // Reset at row 6, then a ramp+1000 frame.
    base = 0;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 500 && !(mph == 1 && mn == 6 * W); k++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("reached_row6", mn, 6 * W);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    run_frame(1000, 0, 0, -1, -1);
    chk("first_15190", first_res, 15190);

    // start pulsed during STREAM and in DONE, then idle with in_valid high, then new frame.
    run_frame(0, 0, 0, -1, FILLN + 5);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
    run_frame(200, 0, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
